// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like port, in-order response routing.
// Optional `SRAM_ARB_RR_EN: round-robin between I and D when both request in IDLE.
module sram_req_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;

  logic pick_d, own_i, own_d, own_req;
  logic full, empty, accept, pop, head;

`ifdef SRAM_ARB_RR_EN
  logic prio_d_q, prio_d_d;
  assign pick_d = data_req & (~inst_req | prio_d_q);
`else
  assign pick_d = data_req;
`endif

  always_comb begin
    own_i = 1'b0;
    own_d = 1'b0;
    unique case (state_q)
      LOCK_I: own_i = 1'b1;
      LOCK_D: own_d = 1'b1;
      default: begin
        own_d = pick_d;
        own_i = inst_req & ~pick_d;
      end
    endcase
  end

  assign own_req = (own_i & inst_req) | (own_d & data_req);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign mem_req = resetn & own_req & ~full;
  assign accept  = mem_req & mem_addr_ok;
  assign pop     = resetn & mem_data_ok & ~empty;
  assign head    = fifo_q[rptr_q];

  assign inst_addr_ok = accept & own_i;
  assign data_addr_ok = accept & own_d;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn) begin
      unique case (1'b1)
        own_d: begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end
        own_i: begin
          mem_wr    = inst_wr;
          mem_size  = inst_size;
          mem_wstrb = inst_wstrb;
          mem_addr  = inst_addr;
          mem_wdata = inst_wdata;
        end
        default: ;
      endcase
    end
  end

  // A stalled grant locks; a dropped request releases the lock.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (mem_req && !mem_addr_ok)
          state_d = own_d ? LOCK_D : LOCK_I;
      LOCK_I:
        if (!inst_req || accept) state_d = IDLE;
      LOCK_D:
        if (!data_req || accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (accept) fifo_d[wptr_q] = own_d;
    wptr_d = wptr_q + AW'(accept);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    prio_d_d = prio_d_q;
    if (accept) prio_d_d = ~own_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prio_d_q <= 1'b1;
    else         prio_d_q <= prio_d_d;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: owner IDs queued at accept,
// checked against *_data_ok routing at response time.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_0100;

  always #5 clk = ~clk;

  sram_req_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check an accept of the expected owner in the current cycle.
  task automatic acc(input string tag, input bit id);
    #1;
    chk({tag, ".mreq"}, 32'(mem_req), 32'd1);
    chk({tag, ".iaok"}, 32'(inst_addr_ok), 32'(!id));
    chk({tag, ".daok"}, 32'(data_addr_ok), 32'(id));
    chk({tag, ".addr"}, mem_addr, id ? data_addr : inst_addr);
    exp_q.push_back(id);
  endtask

  // One cycle of mem_data_ok; routing checked against the queue head.
  task automatic resp(input string tag, input logic [31:0] rd);
    bit e;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".spi"}, 32'(inst_data_ok), 32'd0);
      chk({tag, ".spd"}, 32'(data_data_ok), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".idok"}, 32'(inst_data_ok), 32'(!e));
      chk({tag, ".ddok"}, 32'(data_data_ok), 32'(e));
      chk({tag, ".rd"}, e ? data_rdata : inst_rdata, rd);
    end
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic idle_in();
    inst_req = 0; data_req = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  initial begin
    resetn = 0;
    inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_wdata = 32'h1111_2222; inst_addr = IA;
    data_wr = 1; data_size = 2'd1; data_wstrb = 4'h3;
    data_wdata = 32'h5555_aaaa; data_addr = DA;
    inst_req = 1; data_req = 1;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0bad_cafe;
    #12;
    chk("rst.mreq", 32'(mem_req), 32'd0);
    chk("rst.aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst.dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.rdata", data_rdata, 32'h0bad_cafe);
    idle_in();
    step();
    resetn = 1;
    step();

    // Basic D read/write path
    data_req = 1; mem_addr_ok = 1;
    acc("t1", 1'b1);
    chk("t1.wdata", mem_wdata, 32'h5555_aaaa);
    chk("t1.wstrb", 32'(mem_wstrb), 32'h3);
    chk("t1.wr", 32'(mem_wr), 32'd1);
    step();
    idle_in();
    resp("t1r", 32'hdead_beef);

    // Conflict with stalled address handshake
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2.addr", mem_addr, DA);
      chk("t2.daok", 32'(data_addr_ok), 32'd0);
      step();
    end
    mem_addr_ok = 1;
    acc("t2", 1'b1);
    step();
    idle_in();
    resp("t2r", 32'h0000_0002);
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
`ifdef SRAM_ARB_RR_EN
    acc("t2rr", 1'b0);
`else
    acc("t2fx", 1'b1);
`endif
    step();
    idle_in();
    resp("t2rr.r", 32'h0000_0003);

    // LOCK_I is not preempted by a later D request
    inst_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3.lk", mem_addr, IA);
      step();
    end
    data_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3.hold", mem_addr, IA);
      chk("t3.daok", 32'(data_addr_ok), 32'd0);
      step();
    end
    mem_addr_ok = 1;
    acc("t3i", 1'b0);
    step();
    inst_req = 0;
    acc("t3d", 1'b1);
    step();

    // Full: no request issued, even with a same-cycle pop
    data_req = 1; mem_addr_ok = 1;
    #1;
    chk("t4.full", 32'(mem_req), 32'd0);
    chk("t4.daok", 32'(data_addr_ok), 32'd0);
    step();
    mem_data_ok = 1; mem_rdata = 32'h0000_0044;
    #1;
    chk("t4.nobyp", 32'(mem_req), 32'd0);
    chk("t4.idok", 32'(inst_data_ok), 32'(!exp_q.pop_front()));
    step();
    idle_in();
    resp("t4r", 32'h0000_0045);

    // Push and pop in one cycle at count 1
    inst_req = 1; mem_addr_ok = 1;
    acc("t5i", 1'b0);
    step();
    inst_req = 0; data_req = 1;
    mem_data_ok = 1; mem_rdata = 32'h0000_0055;
    acc("t5d", 1'b1);
    chk("t5.idok", 32'(inst_data_ok), 32'(!exp_q.pop_front()));
    chk("t5.ddok", 32'(data_data_ok), 32'd0);
    step();
    idle_in();
    resp("t5r", 32'h0000_0056);
    resp("t5sp", 32'h0000_0057);

    // Asynchronous reset with two outstanding
    inst_req = 1; mem_addr_ok = 1;
    acc("t6i", 1'b0);
    step();
    inst_req = 0; data_req = 1;
    acc("t6d", 1'b1);
    step();
    inst_req = 1; data_req = 0; mem_data_ok = 1;
    #2;
    resetn = 0;
    #1;
    chk("t6.mreq", 32'(mem_req), 32'd0);
    chk("t6.aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("t6.dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    exp_q.delete();
    idle_in();
    step();
    resetn = 1;
    step();
    resp("t6sp", 32'h0000_0066);
    data_req = 1; mem_addr_ok = 1;
    acc("t6n", 1'b1);
    step();
    idle_in();
    resp("t6r", 32'h0000_0067);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
